// File: rtl/grammer_test_pkg.sv
// Shared types and constants for the grammer_test serial pattern detector.
// The progress helper encodes the overlap rules for any 4-bit pattern.
package grammer_test_pkg;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S11  = 2'd2,
        S110 = 2'd3
    } state_t;

    localparam logic [3:0] REPORT_TAG = 4'hA;

    // Returns {hit, next_progress}: the state value is the number of leading
    // pattern bits matched so far. After a full match the next progress is the
    // longest proper prefix of pat that is also a suffix of what was seen.
    function automatic logic [2:0] pattern_advance(
        input logic [3:0] pat,
        input logic [1:0] k,
        input logic       b
    );
        logic [4:0] seq;
        int         n;
        int         best;
        logic       ok;
        logic       full;
        seq = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(k)) seq = {seq[3:0], pat[3-i]};
        end
        seq  = {seq[3:0], b};
        n    = int'(k) + 1;
        full = (n == 4) && (seq[3:0] == pat);
        best = 0;
        for (int len = 1; len <= 3; len++) begin
            ok = (len <= n);
            for (int j = 0; j < 3; j++) begin
                if (j < len) begin
                    if (seq[j] != pat[4-len+j]) ok = 1'b0;
                end
            end
            if (ok) best = len;
        end
        return {full, best[1:0]};
    endfunction

endpackage

// File: rtl/grammer_test_seq_det.sv
// Mealy detector for a 4-bit serial pattern with overlapping matches.
// hit is combinational from the current state and input bit.
module grammer_test_seq_det
    import grammer_test_pkg::*;
#(
    parameter logic [3:0] PATTERN = 4'b1101
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic hit
);

    state_t     state_reg;
    logic [2:0] adv;

    assign adv = pattern_advance(PATTERN, state_reg, in);
    assign hit = adv[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_t'(adv[1:0]);
        end
    end

endmodule

// File: rtl/grammer_test.sv
// Serial observation target: 8-bit history shift register, pattern match
// counter (saturating) and a registered result that shows history or a match report.
module grammer_test
    import grammer_test_pkg::*;
#(
    parameter int         DATA_W  = 8,
    parameter logic [3:0] PATTERN = 4'b1101,
    parameter int         CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic [DATA_W-1:0] out,
    input  logic              __obs
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              hit;
    logic [DATA_W-1:0] hist_reg;
    logic [DATA_W-1:0] hist_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] report;

    grammer_test_seq_det #(
        .PATTERN (PATTERN)
    ) u_seq_det (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .hit   (hit)
    );

    always_comb begin
        hist_next = {hist_reg[DATA_W-2:0], in};
        cnt_next  = cnt_reg;
        if (hit && (cnt_reg != CNT_MAX)) cnt_next = cnt_reg + CNT_W'(1);
        // Report carries the post-increment count so it reflects this match.
        report = '0;
        report[CNT_W+3:0] = {REPORT_TAG, cnt_next};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_reg <= '0;
            cnt_reg  <= '0;
            out_reg  <= '0;
        end else begin
            hist_reg <= hist_next;
            cnt_reg  <= cnt_next;
            if (__obs) begin
                out_reg <= hist_next;
            end else if (hit) begin
                out_reg <= report;
            end
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_grammer_test.sv
// Randomised and directed bench for grammer_test with a queue-based scoreboard.
// The reference model tracks the raw bit stream and matches on its last four bits.
module tb_grammer_test;

    localparam logic [3:0] PAT = 4'b1101;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       obs = 1'b0;
    logic [7:0] dout;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];

    // reference model state
    logic [7:0] m_hist = 8'h00;
    int         m_seen = 0;
    int         m_cnt = 0;
    logic [7:0] m_out = 8'h00;

    grammer_test dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .out   (dout),
        .__obs (obs)
    );

    always #5 clk = ~clk;

    // monitor: one expected value per clock edge
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (dout !== e) begin
                    bad++;
                    $display("FAIL out cycle=%0d got=%h want=%h", cyc, dout, e);
                end else begin
                    $display("ok   out cycle=%0d in=%0b obs=%0b out=%h", cyc, din, obs, dout);
                end
            end
        end
    end

    task automatic model_reset();
        m_hist = 8'h00;
        m_seen = 0;
        m_cnt  = 0;
        m_out  = 8'h00;
    endtask

    // Drive one bit at the falling edge and queue the value out must take after the next rise.
    task automatic step(input logic b, input logic o);
        logic [7:0] nh;
        logic       match;
        din = b;
        obs = o;
        nh  = {m_hist[6:0], b};
        m_seen++;
        match = (m_seen >= 4) && (nh[3:0] == PAT);
        if (match && m_cnt < 15) m_cnt++;
        if (o) m_out = nh;
        else if (match) m_out = {4'hA, 4'(m_cnt)};
        m_hist = nh;
        exp_q.push_back(m_out);
        @(negedge clk);
    endtask

    // Pulse reset mid-cycle, check the asynchronous clear, hold one edge in reset.
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (dout !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%h want=00", dout);
        end else begin
            $display("ok   async_reset out=%h", dout);
        end
        model_reset();
        exp_q.push_back(8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_nibble(input logic [3:0] v, input logic o);
        for (int i = 3; i >= 0; i--) step(v[i], o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic b;
        logic o;
        // power-on reset for two edges
        @(negedge clk);
        exp_q.push_back(8'h00);
        @(negedge clk);
        exp_q.push_back(8'h00);
        @(negedge clk);
        reset = 1'b1;

        // random traffic, biased toward ones so matches are frequent
        for (int i = 0; i < 300; i++) begin
            b = ($urandom_range(0, 99) < 65);
            o = ($urandom_range(0, 99) < 25);
            step(b, o);
        end

        // reset after activity, then idle zeros keep out at 00
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // single match, then held while zeros follow
        pulse_reset();
        send_nibble(4'b1101, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // overlapping match 1101101
        pulse_reset();
        step(1, 0); step(1, 0); step(0, 0); step(1, 0);
        step(1, 0); step(0, 0); step(1, 0);
        step(0, 0);

        // observe snapshots, no match inside; then a match shows count 1
        pulse_reset();
        step(1, 1); step(0, 1); step(1, 1); step(1, 1);
        step(0, 1); step(0, 1); step(1, 1); step(0, 1);
        send_nibble(4'b1101, 1'b0);

        // saturation
        pulse_reset();
        for (int i = 0; i < 20; i++) send_nibble(4'b1101, 1'b0);
        send_nibble(4'b1101, 1'b0);

        // reset mid-pattern discards progress
        pulse_reset();
        step(1, 0); step(1, 0); step(0, 0);
        pulse_reset();
        step(1, 0);
        step(0, 0);

        // more random traffic with observe rarely set
        for (int i = 0; i < 200; i++) begin
            b = ($urandom_range(0, 99) < 70);
            o = ($urandom_range(0, 99) < 10);
            step(b, o);
        end

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
